// File: rtl/y_bram_reader.sv
// y_bram_reader: streams length_M 32-bit words out of the y BRAM into a ready/valid port.
// Optional feature: define YREAD_CLEAR_EN to zero each y word right after it has been read.
module y_bram_reader #(
    parameter int addr_y_size = 12,
    parameter int length_M    = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            ps_control,
    output logic [31:0]            pl_status,
    output logic [addr_y_size-1:0] bram_addr_y,
    input  logic [31:0]            bram_rddata_y,
    output logic [31:0]            bram_wrdata_y,
    output logic [3:0]             bram_we_y,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int IW = $clog2(length_M) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(length_M - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic [IW-1:0]          rd_idx;
    logic [IW-1:0]          out_idx;
    logic                   rd_pending;
    logic [1:0]             fifo_count;
    logic [31:0]            fifo_head;
    logic [31:0]            fifo_tail;
    logic [addr_y_size-1:0] addr_hold;
    logic [addr_y_size-1:0] read_addr;
    logic [addr_y_size-1:0] clr_addr;
    logic [IW+1:0]          read_byte;
    logic [2:0]             occupancy;
    logic                   clr_pending;
    logic                   push;
    logic                   pop;
    logic                   issue;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   unused_ctrl;

    assign start       = ps_control[0];
    assign unused_ctrl = &{1'b0, ps_control[31:1]};

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_head;
    assign out_last  = out_valid && (out_idx == LAST_IDX);
    assign pop       = out_valid && out_ready;
    assign push      = rd_pending;

    // A pop in the same cycle frees a slot, which is what sustains one read per cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending};
    assign issue     = (state == S_RUN) && !clr_pending
                       && (occupancy < (3'd2 + {2'b00, pop}));

    assign read_byte = {rd_idx, 2'b00};
    assign read_addr = addr_y_size'(read_byte);

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pl_status = {30'd0, busy, done};

    assign bram_wrdata_y = 32'h0;
    assign bram_we_y     = clr_pending ? 4'hf : 4'h0;

    always_comb begin
        bram_addr_y = addr_hold;
        if (clr_pending) begin
            bram_addr_y = clr_addr;
        end else if (issue) begin
            bram_addr_y = read_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            rd_idx  <= '0;
            out_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        rd_idx  <= '0;
                        out_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        rd_idx <= rd_idx + IW'(1);
                        if (rd_idx == LAST_IDX) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
            endcase
            if (pop) begin
                out_idx <= out_idx + IW'(1);
            end
        end
    end

    // Two-entry FIFO: head is the output register, tail only fills while head is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            fifo_count <= 2'd0;
            fifo_head  <= 32'h0;
            fifo_tail  <= 32'h0;
            addr_hold  <= '0;
        end else begin
            rd_pending <= issue;
            addr_hold  <= bram_addr_y;
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        fifo_head <= bram_rddata_y;
                    end else begin
                        fifo_tail <= bram_rddata_y;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= bram_rddata_y;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= bram_rddata_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef YREAD_CLEAR_EN
    // The zero write takes the port the cycle after each read, so reads alternate with writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_pending <= 1'b0;
            clr_addr    <= '0;
        end else begin
            clr_pending <= issue;
            clr_addr    <= read_addr;
        end
    end
`else
    assign clr_pending = 1'b0;
    assign clr_addr    = '0;
`endif

endmodule

// File: tb/tb_y_bram_reader.sv
// Bench for y_bram_reader: BRAM model, queue-free index model of the expected stream, per-cycle compare.
// Also covers the YREAD_CLEAR_EN build when the macro is defined for both files.
module tb_y_bram_reader;

    localparam int AW    = 12;
    localparam int L     = 128;
    localparam int DEPTH = 1 << (AW - 2);

    logic          clk;
    logic          reset;
    logic [31:0]   ps_control;
    logic [31:0]   pl_status;
    logic [AW-1:0] bram_addr_y;
    logic [31:0]   bram_rddata_y;
    logic [31:0]   bram_wrdata_y;
    logic [3:0]    bram_we_y;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem       [DEPTH];
    logic [31:0] init_mem  [DEPTH];
    logic [31:0] exp_words [L];
    logic        load_req  = 1'b0;
    int          ready_mode = 0;
    int          ready_cnt;
    int          acc        = 0;
    int          max_issued = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic [31:0] first_word = 32'h0;
    logic [31:0] last_word  = 32'h0;
    int          cyc;
    int          n;

    y_bram_reader #(.addr_y_size(AW), .length_M(L)) dut (
        .clk           (clk),
        .reset         (reset),
        .ps_control    (ps_control),
        .pl_status     (pl_status),
        .bram_addr_y   (bram_addr_y),
        .bram_rddata_y (bram_rddata_y),
        .bram_wrdata_y (bram_wrdata_y),
        .bram_we_y     (bram_we_y),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous BRAM: read data appears the cycle after the address, read-before-write.
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= init_mem[k];
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we_y[b]) mem[bram_addr_y[AW-1:2]][8*b +: 8] <= bram_wrdata_y[8*b +: 8];
            end
        end
        bram_rddata_y <= mem[bram_addr_y[AW-1:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        ready_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ps_control[0]) ready_cnt++;
            else ready_cnt = 0;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = (ready_cnt > 20);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model: word k of a run must be exp_words[k]; acc counts accepted words, max_issued the highest word read.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc        = 0;
                max_issued = -1;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("stall_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (acc < L) begin
                        checkOutput("word", out_data, exp_words[acc]);
                        checkOutput("last_flag", {31'd0, out_last}, {31'd0, acc == L - 1});
                        if (acc == 0) first_word = out_data;
                        if (acc == L - 1) last_word = out_data;
                        acc++;
                    end else begin
                        checkOutput("extra_word", {31'd0, out_valid}, 32'd0);
                    end
                end
`ifndef YREAD_CLEAR_EN
                checkOutput("no_write_we", {28'd0, bram_we_y}, 32'd0);
                checkOutput("no_write_data", bram_wrdata_y, 32'd0);
`endif
                if (pl_status[1]) begin
                    if (bram_we_y == 4'h0 && int'(bram_addr_y >> 2) > max_issued) max_issued = int'(bram_addr_y >> 2);
                    checkOutput("addr_bound", {31'd0, int'(bram_addr_y) <= 4 * (L - 1)}, 32'd1);
                    checkOutput("outstanding", {31'd0, (max_issued + 1 - acc) <= 2}, 32'd1);
                end
                if (pl_status[1:0] == 2'b00) begin
                    checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
                    acc        = 0;
                    max_issued = -1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic loadMem(input int pattern);
        for (int k = 0; k < DEPTH; k++) init_mem[k] = (pattern == 0) ? 32'(k + 1) : $urandom;
        for (int k = 0; k < L; k++) exp_words[k] = init_mem[k];
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int mode, input int pattern, input bit hold, output int cycles);
        int first_valid;
        ready_mode = mode;
        loadMem(pattern);
        ps_control  = $urandom | 32'h1;
        first_valid = 0;
        cycles      = 0;
        while (cycles < 600 && !pl_status[0]) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            #1;
            if (out_valid && first_valid == 0) first_valid = cycles;
            if (mode == 1 && cycles == 10) ps_control[0] = 1'b0;
        end
        checkOutput("done_reached", {31'd0, pl_status[0]}, 32'd1);
        checkOutput("words_accepted", acc, L);
        checkOutput("first_valid_gap", {31'd0, first_valid >= 3}, 32'd1);
        checkOutput("busy_at_done", {31'd0, pl_status[1]}, 32'd0);
`ifdef YREAD_CLEAR_EN
        for (int k = 0; k < L; k++) checkOutput("cleared", mem[k], 32'd0);
`endif
        if (!hold) begin
            ps_control = $urandom & 32'hFFFF_FFFE;
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("done_cleared", pl_status, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b0;
        ps_control = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_status", pl_status, 32'd0);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_last", {31'd0, out_last}, 32'd0);
        checkOutput("reset_data", out_data, 32'd0);
        checkOutput("reset_addr", {20'd0, bram_addr_y}, 32'd0);
        checkOutput("reset_we", {28'd0, bram_we_y}, 32'd0);
        checkOutput("reset_wrdata", bram_wrdata_y, 32'd0);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;

        $display("[TB] run A: ready held high, mem[k]=k+1, start held after done");
        applyStimulus(0, 0, 1'b1, cyc);
        checkOutput("first_word", first_word, 32'd1);
        checkOutput("last_word", last_word, 32'd128);
`ifdef YREAD_CLEAR_EN
        checkOutput("run_cycles", {31'd0, cyc >= 256 && cyc <= 262}, 32'd1);
`else
        checkOutput("run_cycles", {31'd0, cyc >= 129 && cyc <= 134}, 32'd1);
`endif
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("hold_done", pl_status, 32'd1);
            checkOutput("hold_no_valid", {31'd0, out_valid}, 32'd0);
        end
        ps_control = 32'h0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("release_done", pl_status, 32'd0);

        $display("[TB] run B: ready toggling, start dropped mid-run");
        applyStimulus(1, 0, 1'b0, cyc);
        checkOutput("toggle_first", first_word, 32'd1);
        checkOutput("toggle_last", last_word, 32'd128);

        $display("[TB] run C: ready low for 20 cycles after start");
        applyStimulus(2, 1, 1'b0, cyc);

        $display("[TB] run D: reset after word 50, then restart");
        ready_mode = 3;
        loadMem(1);
        ps_control = 32'h1;
        n = 0;
        while (acc < 50 && n < 1000) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("reached_word50", {31'd0, acc >= 50}, 32'd1);
        reset      = 1'b0;
        ps_control = 32'h0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("post_reset_status", pl_status, 32'd0);
        end
        applyStimulus(3, 1, 1'b0, cyc);
        checkOutput("restart_first", first_word, exp_words[0]);

        $display("[TB] runs E: random ready, random data");
        for (int r = 0; r < 3; r++) applyStimulus(3, 1, 1'b0, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
